// File: rtl/tx_link_driver.sv
// Transmit word driver for an 8-bit-per-clk160 serial lane: FIFO data, PRBS7/fixed training words
// and a stepped ODELAY tap controller (built only when TX_DELAY_CTRL_EN is defined).
module tx_link_driver #(
  parameter logic [7:0]  IDLE_WORD   = 8'hAC,
  parameter logic [6:0]  PRBS_SEED   = 7'h7F,
  parameter int unsigned TRAIN_WORDS = 256,
  parameter int unsigned MAX_STEP    = 8
) (
  input  logic       clk160,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] fixed_pattern,
  input  logic [7:0] fifo_data,
  input  logic       fifo_valid,
  output logic       fifo_rd,
  output logic [7:0] D_IN,
  output logic       train_done,
  input  logic [8:0] delay_in,
  input  logic       delay_set,
  input  logic [8:0] delay_out,
  output logic [8:0] delay_set_value,
  output logic       delay_wr,
  output logic       delay_ready
);

  localparam logic [1:0]  ModeData   = 2'd0;
  localparam logic [1:0]  ModePrbs   = 2'd1;
  localparam logic [1:0]  ModeFixed  = 2'd2;
  localparam logic [1:0]  ModeIdle   = 2'd3;
  localparam logic [15:0] TrainWords = 16'(TRAIN_WORDS);

  logic [1:0]  mode_q;
  logic        mode_chg;
  logic [6:0]  lfsr_q, lfsr_d;
  logic [6:0]  prbs_s;
  logic        prbs_nb;
  logic [7:0]  prbs_word;
  logic [7:0]  d_in_d;
  logic [15:0] train_cnt_q, train_cnt_d;
  logic        training;

  assign fifo_rd  = (mode == ModeData) && fifo_valid && !rst;
  assign mode_chg = (mode != mode_q);
  assign training = (mode_q == ModePrbs) || (mode_q == ModeFixed);

  // Eight Fibonacci steps per word; the first new bit lands in D_IN[7].
  always_comb begin
    prbs_s    = lfsr_q;
    prbs_nb   = 1'b0;
    prbs_word = '0;
    for (int i = 0; i < 8; i++) begin
      prbs_nb          = prbs_s[6] ^ prbs_s[5];
      prbs_s           = {prbs_s[5:0], prbs_nb};
      prbs_word[7 - i] = prbs_nb;
    end
  end

  // The word path follows mode_q, so a new mode shows up two cycles after it is applied.
  // A FIFO pop is the exception: it follows the live mode so no popped word is dropped.
  always_comb begin
    d_in_d      = IDLE_WORD;
    lfsr_d      = lfsr_q;
    train_cnt_d = train_cnt_q;
    if (fifo_rd) begin
      d_in_d = fifo_data;
    end else begin
      case (mode_q)
        ModePrbs:  d_in_d = prbs_word;
        ModeFixed: d_in_d = fixed_pattern;
        default:   d_in_d = IDLE_WORD;
      endcase
    end
    if (mode_q == ModePrbs) lfsr_d = prbs_s;
    if (mode_chg && (mode == ModePrbs)) lfsr_d = PRBS_SEED;
    if (mode_chg) begin
      train_cnt_d = '0;
    end else if (training && (train_cnt_q != TrainWords)) begin
      train_cnt_d = train_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      mode_q      <= ModeIdle;
      lfsr_q      <= PRBS_SEED;
      D_IN        <= IDLE_WORD;
      train_cnt_q <= '0;
    end else begin
      mode_q      <= mode;
      lfsr_q      <= lfsr_d;
      D_IN        <= d_in_d;
      train_cnt_q <= train_cnt_d;
    end
  end

  assign train_done = training && (train_cnt_q == TrainWords);

`ifdef TX_DELAY_CTRL_EN
  typedef enum logic [1:0] {DCheck, DWrite, DSettle, DIdle} dstate_e;

  localparam logic signed [9:0] MaxStep = 10'(MAX_STEP);
  localparam logic [8:0]        Step9   = 9'(MAX_STEP);

  dstate_e            dstate_q, dstate_d;
  logic [2:0]         set_sr_q;
  logic               capture;
  logic [8:0]         target_q, target_d;
  logic [2:0]         settle_q, settle_d;
  logic [8:0]         set_value_d;
  logic signed [9:0]  diff;

  assign capture = (set_sr_q == 3'b001);

  always_comb begin
    dstate_d    = dstate_q;
    target_d    = capture ? delay_in : target_q;
    settle_d    = settle_q;
    set_value_d = delay_set_value;
    diff        = $signed({1'b0, target_q}) - $signed({1'b0, delay_out});
    case (dstate_q)
      DCheck: begin
        if (delay_out == target_q) begin
          // A capture landing here must be re-checked rather than reported as ready.
          dstate_d = capture ? DCheck : DIdle;
        end else begin
          if (diff > MaxStep) begin
            set_value_d = delay_out + Step9;
          end else if (diff < -MaxStep) begin
            set_value_d = delay_out - Step9;
          end else begin
            set_value_d = target_q;
          end
          dstate_d = DWrite;
        end
      end
      DWrite: begin
        settle_d = 3'd4;
        dstate_d = DSettle;
      end
      DSettle: begin
        settle_d = settle_q - 3'd1;
        if (settle_q == 3'd1) dstate_d = DCheck;
      end
      DIdle: begin
        if (capture) dstate_d = DCheck;
      end
      default: dstate_d = DCheck;
    endcase
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      dstate_q        <= DCheck;
      set_sr_q        <= '0;
      target_q        <= '0;
      settle_q        <= '0;
      delay_set_value <= '0;
    end else begin
      dstate_q        <= dstate_d;
      set_sr_q        <= {set_sr_q[1:0], delay_set};
      target_q        <= target_d;
      settle_q        <= settle_d;
      delay_set_value <= set_value_d;
    end
  end

  assign delay_wr    = (dstate_q == DWrite);
  assign delay_ready = (dstate_q == DIdle);
`else
  logic set_q;
  logic unused_dly;

  assign unused_dly  = ^delay_out ^ (MAX_STEP != 0);
  assign delay_ready = !rst;

  always_ff @(posedge clk160) begin
    if (rst) begin
      set_q           <= 1'b0;
      delay_wr        <= 1'b0;
      delay_set_value <= '0;
    end else begin
      set_q           <= delay_set;
      delay_wr        <= delay_set && !set_q;
      delay_set_value <= delay_in;
    end
  end
`endif

endmodule

// File: tb/tb_tx_link_driver.sv
// Directed bench for tx_link_driver: word path, training counter and the delay path of whichever
// build (TX_DELAY_CTRL_EN defined or not) is compiled.
module tb_tx_link_driver;

  logic       clk160 = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd3;
  logic [7:0] fixed_pattern = 8'h00;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_valid = 1'b0;
  logic       fifo_rd;
  logic [7:0] D_IN;
  logic       train_done;
  logic [8:0] delay_in = 9'd0;
  logic       delay_set = 1'b0;
  logic [8:0] delay_out;
  logic [8:0] delay_set_value;
  logic       delay_wr;
  logic       delay_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  tx_link_driver dut (
    .clk160          (clk160),
    .rst             (rst),
    .mode            (mode),
    .fixed_pattern   (fixed_pattern),
    .fifo_data       (fifo_data),
    .fifo_valid      (fifo_valid),
    .fifo_rd         (fifo_rd),
    .D_IN            (D_IN),
    .train_done      (train_done),
    .delay_in        (delay_in),
    .delay_set       (delay_set),
    .delay_out       (delay_out),
    .delay_set_value (delay_set_value),
    .delay_wr        (delay_wr),
    .delay_ready     (delay_ready)
  );

  always #5 clk160 = ~clk160;
  always @(posedge clk160) cyc <= cyc + 1;

  // ODELAY model: LOAD sampled at an edge shows on CNTVALUEOUT two edges later; tap 0 on lane reset.
  logic       p0 = 1'b0, p1 = 1'b0;
  logic [8:0] p0v = 9'd0, p1v = 9'd0, dout = 9'd0;
  always @(posedge clk160) begin
    if (rst) begin
      p0 <= 1'b0; p1 <= 1'b0; p0v <= 9'd0; p1v <= 9'd0; dout <= 9'd0;
    end else begin
      p0 <= delay_wr; p0v <= delay_set_value;
      p1 <= p0;       p1v <= p0v;
      if (p1) dout <= p1v;
    end
  end
  assign delay_out = dout;

  logic [8:0] wr_val[$];
  int         wr_cyc[$];
  always @(negedge clk160) begin
    if (delay_wr === 1'b1) begin
      wr_val.push_back(delay_set_value);
      wr_cyc.push_back(cyc);
    end
  end

  logic [6:0] ms;
  task automatic model_word(output logic [7:0] w);
    logic nb;
    for (int i = 0; i < 8; i++) begin
      nb       = ms[6] ^ ms[5];
      ms       = {ms[5:0], nb};
      w[7 - i] = nb;
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk160);
  endtask

  task automatic pulse_set(input logic [8:0] v);
    delay_in  = v;
    delay_set = 1'b1;
    step();
    delay_set = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 2'd0; fifo_valid = 1'b1; fifo_data = 8'h55;
    step(3);
    n_cmp++; if (D_IN !== 8'hAC) begin n_bad++; $display("FAIL rst_d_in got %h want ac", D_IN); end
    n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL rst_fifo_rd got %b want 0", fifo_rd); end
    n_cmp++; if (train_done !== 1'b0) begin n_bad++; $display("FAIL rst_train_done got %b want 0", train_done); end
    n_cmp++; if (delay_set_value !== 9'd0) begin n_bad++; $display("FAIL rst_set_value got %0d want 0", delay_set_value); end
    n_cmp++; if (delay_wr !== 1'b0) begin n_bad++; $display("FAIL rst_delay_wr got %b want 0", delay_wr); end
    n_cmp++; if (delay_ready !== 1'b0) begin n_bad++; $display("FAIL rst_delay_ready got %b want 0", delay_ready); end
    mode = 2'd3; fifo_valid = 1'b0;
    step();
    rst = 1'b0;
    step(2);
    n_cmp++; if (D_IN !== 8'hAC) begin n_bad++; $display("FAIL idle_d_in got %h want ac", D_IN); end
    n_cmp++; if (delay_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got %b want 1", delay_ready); end
  endtask

  task automatic test_prbs;
    logic [7:0] w;
    ms = 7'h7F;
    mode = 2'd1;
    step();
    n_cmp++; if (D_IN !== 8'hAC) begin n_bad++; $display("FAIL prbs_latency got %h want ac", D_IN); end
    step();
    n_cmp++; if (D_IN !== 8'h02) begin n_bad++; $display("FAIL prbs_w0 got %h want 02", D_IN); end
    n_cmp++; if (train_done !== 1'b0) begin n_bad++; $display("FAIL prbs_done_w0 got %b want 0", train_done); end
    step();
    n_cmp++; if (D_IN !== 8'h0C) begin n_bad++; $display("FAIL prbs_w1 got %h want 0c", D_IN); end
    model_word(w);
    model_word(w);
    for (int i = 2; i < 260; i++) begin
      step();
      model_word(w);
      n_cmp++; if (D_IN !== w) begin n_bad++; $display("FAIL prbs_w%0d got %h want %h", i, D_IN, w); end
      n_cmp++;
      if (train_done !== (i >= 255)) begin
        n_bad++; $display("FAIL prbs_done_w%0d got %b want %b", i, train_done, (i >= 255));
      end
      if (i == 127) begin
        n_cmp++; if (D_IN !== 8'h02) begin n_bad++; $display("FAIL prbs_period got %h want 02", D_IN); end
      end
    end
  endtask

  task automatic test_mode_switch;
    logic [7:0] w, exp_fp;
    mode = 2'd2; fixed_pattern = 8'h5A; exp_fp = 8'h5A;
    step();
    model_word(w);
    n_cmp++; if (D_IN !== w) begin n_bad++; $display("FAIL sw_tail got %h want %h", D_IN, w); end
    n_cmp++; if (train_done !== 1'b0) begin n_bad++; $display("FAIL sw_clr_12 got %b want 0", train_done); end
    for (int i = 0; i < 260; i++) begin
      step();
      n_cmp++; if (D_IN !== exp_fp) begin n_bad++; $display("FAIL fixed_w%0d got %h want %h", i, D_IN, exp_fp); end
      n_cmp++;
      if (train_done !== (i >= 255)) begin
        n_bad++; $display("FAIL fixed_done_w%0d got %b want %b", i, train_done, (i >= 255));
      end
      if (i == 100) begin fixed_pattern = 8'hC3; exp_fp = 8'hC3; end
    end
    mode = 2'd1;
    step();
    n_cmp++; if (D_IN !== 8'hC3) begin n_bad++; $display("FAIL sw_fixed_tail got %h want c3", D_IN); end
    n_cmp++; if (train_done !== 1'b0) begin n_bad++; $display("FAIL sw_clr_21 got %b want 0", train_done); end
    step();
    n_cmp++; if (D_IN !== 8'h02) begin n_bad++; $display("FAIL sw_prbs_w0 got %h want 02", D_IN); end
    step();
    n_cmp++; if (D_IN !== 8'h0C) begin n_bad++; $display("FAIL sw_prbs_w1 got %h want 0c", D_IN); end
  endtask

  task automatic test_fifo;
    mode = 2'd0; fifo_valid = 1'b0;
    step(3);
    n_cmp++; if (D_IN !== 8'hAC) begin n_bad++; $display("FAIL fifo_empty got %h want ac", D_IN); end
    fifo_valid = 1'b1; fifo_data = 8'h11; #1;
    n_cmp++; if (fifo_rd !== 1'b1) begin n_bad++; $display("FAIL fifo_rd0 got %b want 1", fifo_rd); end
    step();
    n_cmp++; if (D_IN !== 8'h11) begin n_bad++; $display("FAIL fifo_w0 got %h want 11", D_IN); end
    fifo_data = 8'h22; #1;
    n_cmp++; if (fifo_rd !== 1'b1) begin n_bad++; $display("FAIL fifo_rd1 got %b want 1", fifo_rd); end
    step();
    n_cmp++; if (D_IN !== 8'h22) begin n_bad++; $display("FAIL fifo_w1 got %h want 22", D_IN); end
    fifo_valid = 1'b0; #1;
    n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL fifo_rd2 got %b want 0", fifo_rd); end
    step();
    n_cmp++; if (D_IN !== 8'hAC) begin n_bad++; $display("FAIL fifo_drain got %h want ac", D_IN); end
    mode = 2'd3; fifo_valid = 1'b1; #1;
    n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL fifo_rd_mode3 got %b want 0", fifo_rd); end
    fifo_valid = 1'b0;
    step(3);
  endtask

`ifdef TX_DELAY_CTRL_EN
  task automatic test_delay_step;
    logic [8:0] e[5] = '{9'd8, 9'd16, 9'd24, 9'd32, 9'd37};
    int n = 0;
    wr_val.delete(); wr_cyc.delete();
    pulse_set(9'd37);
    step();
    n_cmp++; if (delay_ready !== 1'b0) begin n_bad++; $display("FAIL step_ready_drop got %b want 0", delay_ready); end
    while (delay_ready !== 1'b1 && n < 100) begin step(); n++; end
    n_cmp++; if (delay_ready !== 1'b1) begin n_bad++; $display("FAIL step_ready_timeout got %b want 1", delay_ready); end
    n_cmp++;
    if (wr_val.size() != 5) begin n_bad++; $display("FAIL step_count got %0d want 5", wr_val.size()); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k >= wr_val.size() || wr_val[k] !== e[k]) begin
        n_bad++; $display("FAIL step_wr%0d got %0d want %0d", k, (k < wr_val.size()) ? wr_val[k] : 9'd0, e[k]);
      end
    end
    for (int k = 1; k < wr_cyc.size(); k++) begin
      n_cmp++;
      if (wr_cyc[k] - wr_cyc[k-1] != 6) begin
        n_bad++; $display("FAIL step_cadence%0d got %0d want 6", k, wr_cyc[k] - wr_cyc[k-1]);
      end
    end
    n_cmp++; if (delay_set_value !== 9'd37) begin n_bad++; $display("FAIL step_final got %0d want 37", delay_set_value); end
  endtask

  task automatic test_delay_retarget;
    logic [8:0] e[7] = '{9'd45, 9'd53, 9'd61, 9'd69, 9'd77, 9'd85, 9'd90};
    int n = 0;
    wr_val.delete(); wr_cyc.delete();
    pulse_set(9'd100);
    while (delay_wr !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (delay_wr !== 1'b1) begin n_bad++; $display("FAIL retgt_first_wr got %b want 1", delay_wr); end
    delay_in = 9'd90; delay_set = 1'b1;
    step();
    delay_set = 1'b0;
    n = 0;
    while (delay_ready !== 1'b1 && n < 200) begin step(); n++; end
    n_cmp++; if (delay_ready !== 1'b1) begin n_bad++; $display("FAIL retgt_ready_timeout got %b want 1", delay_ready); end
    n_cmp++;
    if (wr_val.size() != 7) begin n_bad++; $display("FAIL retgt_count got %0d want 7", wr_val.size()); end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (k >= wr_val.size() || wr_val[k] !== e[k]) begin
        n_bad++; $display("FAIL retgt_wr%0d got %0d want %0d", k, (k < wr_val.size()) ? wr_val[k] : 9'd0, e[k]);
      end
    end
  endtask

  task automatic test_delay_equal;
    wr_val.delete(); wr_cyc.delete();
    pulse_set(9'd90);
    step();
    n_cmp++; if (delay_ready !== 1'b0) begin n_bad++; $display("FAIL eq_ready_drop got %b want 0", delay_ready); end
    step();
    n_cmp++; if (delay_ready !== 1'b1) begin n_bad++; $display("FAIL eq_ready_back got %b want 1", delay_ready); end
    step(8);
    n_cmp++; if (wr_val.size() != 0) begin n_bad++; $display("FAIL eq_no_write got %0d want 0", wr_val.size()); end
  endtask
`else
  task automatic test_delay_bypass;
    delay_in = 9'd37; delay_set = 1'b1; #1;
    n_cmp++; if (delay_ready !== 1'b1) begin n_bad++; $display("FAIL byp_ready got %b want 1", delay_ready); end
    step();
    n_cmp++; if (delay_wr !== 1'b1) begin n_bad++; $display("FAIL byp_wr_rise got %b want 1", delay_wr); end
    n_cmp++; if (delay_set_value !== 9'd37) begin n_bad++; $display("FAIL byp_val0 got %0d want 37", delay_set_value); end
    delay_in = 9'd5;
    step();
    n_cmp++; if (delay_wr !== 1'b0) begin n_bad++; $display("FAIL byp_wr_width got %b want 0", delay_wr); end
    n_cmp++; if (delay_set_value !== 9'd5) begin n_bad++; $display("FAIL byp_val1 got %0d want 5", delay_set_value); end
    delay_set = 1'b0;
    step();
    n_cmp++; if (delay_wr !== 1'b0) begin n_bad++; $display("FAIL byp_wr_fall got %b want 0", delay_wr); end
    delay_set = 1'b1;
    step();
    n_cmp++; if (delay_wr !== 1'b1) begin n_bad++; $display("FAIL byp_wr_rise2 got %b want 1", delay_wr); end
    delay_set = 1'b0;
    step(2);
  endtask
`endif

  task automatic test_rst_mid;
    int base;
`ifdef TX_DELAY_CTRL_EN
    int n = 0;
    pulse_set(9'd200);
    while (delay_wr !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (delay_set_value !== 9'd98) begin n_bad++; $display("FAIL rst_pre_wr got %0d want 98", delay_set_value); end
    step(3);
`else
    delay_in = 9'h1FF;
    step();
`endif
    base = wr_val.size();
    rst = 1'b1; mode = 2'd0; fifo_valid = 1'b1; #1;
    n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL mid_fifo_rd got %b want 0", fifo_rd); end
    step();
    n_cmp++; if (D_IN !== 8'hAC) begin n_bad++; $display("FAIL mid_d_in got %h want ac", D_IN); end
    n_cmp++; if (train_done !== 1'b0) begin n_bad++; $display("FAIL mid_done got %b want 0", train_done); end
    n_cmp++; if (delay_set_value !== 9'd0) begin n_bad++; $display("FAIL mid_set_value got %0d want 0", delay_set_value); end
    n_cmp++; if (delay_wr !== 1'b0) begin n_bad++; $display("FAIL mid_wr got %b want 0", delay_wr); end
    n_cmp++; if (delay_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready got %b want 0", delay_ready); end
    rst = 1'b0; mode = 2'd3; fifo_valid = 1'b0;
    step(20);
    n_cmp++; if (wr_val.size() != base) begin n_bad++; $display("FAIL mid_no_wr got %0d want %0d", wr_val.size(), base); end
    n_cmp++; if (delay_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_after got %b want 1", delay_ready); end
  endtask

  initial begin
    step();
    test_reset();
    test_prbs();
    test_mode_switch();
    test_fifo();
`ifdef TX_DELAY_CTRL_EN
    test_delay_step();
    test_delay_retarget();
    test_delay_equal();
`else
    test_delay_bypass();
`endif
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
